// File: rtl/vga_pkg.sv
// Shared VGA timing defaults for the raster core.
// Default set is 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_CNT_MAX  = 1024;

  function automatic int vga_total(
    input int a,
    input int fp,
    input int s,
    input int bp
  );
    return a + fp + s + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift-enabled delay line carrying sync/active flags to meet the RGB path.
// DEPTH of zero degenerates to a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{clk, rst_n, shift};
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (shift) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA raster generator with render-latency alignment.
// Emits x/y and strobes, re-times sync with returned RGB and blanks it.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_BITS = 4,
  parameter int CLK_DIV    = 1,
  parameter int PIPE_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [3*COLOR_BITS-1:0] rgb_in,
  output logic [9:0]              x,
  output logic [9:0]              y,
  output logic                    pix_tick,
  output logic                    active,
  output logic                    line_start,
  output logic                    frame_start,
  output logic [COLOR_BITS-1:0]   r,
  output logic [COLOR_BITS-1:0]   g,
  output logic [COLOR_BITS-1:0]   b,
  output logic                    hs,
  output logic                    vs
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CB      = COLOR_BITS;

  if (H_TOTAL > VGA_CNT_MAX || V_TOTAL > VGA_CNT_MAX) begin : g_bad_total
    $error("vga_timing_core: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
    $error("vga_timing_core: CLK_DIV out of 1..4");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_lat
    $error("vga_timing_core: PIPE_LAT out of 0..7");
  end

  localparam logic [1:0]  PRE_LAST = 2'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_ON    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [1:0]  pre;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [10:0] hx;
  logic [10:0] vy;
  logic        h_end;
  logic        v_end;
  logic        hs_raw;
  logic        vs_raw;
  logic        hs_d;
  logic        vs_d;
  logic        act_d;

  assign hx    = {1'b0, hcnt};
  assign vy    = {1'b0, vcnt};
  assign h_end = (hx == H_LAST);
  assign v_end = (vy == V_LAST);

  // Gated by rst_n so CLK_DIV=1 shows no strobe while held in reset.
  assign pix_tick    = rst_n & ena & (pre == PRE_LAST);
  assign active      = (hx < H_ACT) && (vy < V_ACT);
  assign line_start  = pix_tick && (hcnt == '0);
  assign frame_start = line_start && (vcnt == '0);
  assign x           = hcnt;
  assign y           = vcnt;

  assign hs_raw = (hx >= HS_ON) && (hx < HS_OFF);
  assign vs_raw = (vy >= VS_ON) && (vy < VS_OFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else if (ena) begin
      pre <= (pre == PRE_LAST) ? 2'd0 : pre + 2'd1;
      if (pix_tick) begin
        hcnt <= h_end ? 10'd0 : hcnt + 10'd1;
        if (h_end) vcnt <= v_end ? 10'd0 : vcnt + 10'd1;
      end
    end
  end

  vga_delay_line #(
    .WIDTH(3),
    .DEPTH(PIPE_LAT)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .shift(pix_tick),
    .d    ({hs_raw, vs_raw, active}),
    .q    ({hs_d, vs_d, act_d})
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r  <= '0;
      g  <= '0;
      b  <= '0;
      hs <= ~HS_POL;
      vs <= ~VS_POL;
    end else if (pix_tick) begin
      r  <= act_d ? rgb_in[3*CB-1 -: CB] : '0;
      g  <= act_d ? rgb_in[2*CB-1 -: CB] : '0;
      b  <= act_d ? rgb_in[CB-1 -: CB]   : '0;
      hs <= hs_d ^ ~HS_POL;
      vs <= vs_d ^ ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// Randomised bench for vga_timing_core against a tick-count raster model.
// Small timing set keeps several whole frames inside a short run.
module tb_vga_timing_core;

  localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
  localparam int VA = 8, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int CD = 2;
  localparam int PL = 2;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [9:0]  x, y;
  logic        pix_tick, active, line_start, frame_start;
  logic [3:0]  r, g, b;
  logic        hs, vs;
  logic [37:0] dut_vec;

  always #5 clk = ~clk;

  vga_timing_core #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .COLOR_BITS(4),
    .CLK_DIV(CD), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rgb_in(rgb_in),
    .x(x), .y(y), .pix_tick(pix_tick), .active(active),
    .line_start(line_start), .frame_start(frame_start),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs)
  );

  assign dut_vec = {x, y, pix_tick, active, line_start,
                    frame_start, hs, vs, r, g, b};

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int n = 0;
  int clk_no = 0;
  logic [2:0] hist[$];
  logic [3:0] m_r = '0, m_g = '0, m_b = '0;
  logic m_hs = !HP, m_vs = !VP;

  function automatic bit m_tick();
    return rst_n && ena && (ecnt % CD == CD - 1);
  endfunction
  function automatic int mx();
    return n % HT;
  endfunction
  function automatic int my();
    return (n / HT) % VT;
  endfunction
  function automatic bit m_act();
    return mx() < HA && my() < VA;
  endfunction
  function automatic bit hs_raw(input int xx);
    return xx >= HA + HF && xx < HA + HF + HSY;
  endfunction
  function automatic bit vs_raw(input int yy);
    return yy >= VA + VF && yy < VA + VF + VSY;
  endfunction
  function automatic logic [37:0] m_vec();
    bit tk;
    bit ls;
    tk = m_tick();
    ls = tk && mx() == 0;
    return {10'(mx()), 10'(my()), tk, m_act(), ls,
            ls && my() == 0, m_hs, m_vs, m_r, m_g, m_b};
  endfunction

  // Pins show the raster position PL ticks back plus rgb sampled now.
  task automatic step();
    bit tk;
    logic [2:0] ent;
    tk = m_tick();
    @(posedge clk);
    clk_no++;
    if (!rst_n) begin
      ecnt = 0;
      n = 0;
      hist.delete();
      m_r = '0; m_g = '0; m_b = '0;
      m_hs = !HP; m_vs = !VP;
    end else if (ena) begin
      if (tk) begin
        hist.push_back({hs_raw(mx()), vs_raw(my()), m_act()});
        ent = (hist.size() > PL) ? hist[hist.size() - 1 - PL] : 3'b000;
        if (hist.size() > PL) void'(hist.pop_front());
        m_hs = ent[2] ^ !HP;
        m_vs = ent[1] ^ !VP;
        m_r = ent[0] ? rgb_in[11:8] : 4'h0;
        m_g = ent[0] ? rgb_in[7:4] : 4'h0;
        m_b = ent[0] ? rgb_in[3:0] : 4'h0;
        n = (n + 1) % (HT * VT);
      end
      ecnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ena = 1'($urandom_range(0, 1));
      rgb_in = 12'($urandom);
      step();
    end
    #1;
    checks++;
    if (x !== 10'd0 || y !== 10'd0) begin
      errors++;
      $display("FAIL reset_xy got %0d,%0d want 0,0", x, y);
    end
    checks++;
    if (pix_tick !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick got %b%b want 00", pix_tick, frame_start);
    end
    checks++;
    if (hs !== !HP || vs !== !VP) begin
      errors++;
      $display("FAIL reset_sync got %b%b want %b%b", hs, vs, !HP, !VP);
    end
    checks++;
    if ({r, g, b} !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb got %h want 000", {r, g, b});
    end
    rst_n = 1'b1;
    ena = 1'b1;
  endtask

  task automatic test_raster(input int ncyc);
    int last_ls;
    int last_fs;
    last_ls = -1;
    last_fs = -1;
    ena = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      rgb_in = 12'($urandom);
      #1;
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        if (errors < 20) $display("FAIL raster got %h want %h", dut_vec, m_vec());
      end
      if (line_start === 1'b1) begin
        if (last_ls >= 0) begin
          checks++;
          if (clk_no - last_ls != HT * CD) begin
            errors++;
            $display("FAIL line_period got %0d want %0d", clk_no - last_ls, HT * CD);
          end
        end
        last_ls = clk_no;
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (clk_no - last_fs != HT * VT * CD) begin
            errors++;
            $display("FAIL frame_period got %0d want %0d", clk_no - last_fs, HT * VT * CD);
          end
        end
        last_fs = clk_no;
      end
      step();
    end
  endtask

  task automatic test_blanking();
    int lit, hs_on, vs_on;
    lit = 0; hs_on = 0; vs_on = 0;
    ena = 1'b1;
    rgb_in = 12'hFFF;
    for (int i = 0; i < HT * VT * CD; i++) begin
      #1;
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        if (errors < 20) $display("FAIL blank got %h want %h", dut_vec, m_vec());
      end
      if (pix_tick === 1'b1) begin
        if ({r, g, b} == 12'hFFF) lit++;
        if (hs == HP) hs_on++;
        if (vs == VP) vs_on++;
      end
      step();
    end
    checks++;
    if (lit != HA * VA) begin
      errors++;
      $display("FAIL lit_pixels got %0d want %0d", lit, HA * VA);
    end
    checks++;
    if (hs_on != HSY * VT) begin
      errors++;
      $display("FAIL hs_ticks got %0d want %0d", hs_on, HSY * VT);
    end
    checks++;
    if (vs_on != VSY * HT) begin
      errors++;
      $display("FAIL vs_ticks got %0d want %0d", vs_on, VSY * HT);
    end
  endtask

  task automatic test_pixel();
    bit seen;
    seen = 0;
    ena = 1'b1;
    for (int i = 0; i < 2 * HT * VT * CD && !seen; i++) begin
      if (mx() == 5 + PL && my() == 0) rgb_in = m_tick() ? 12'hF0A : 12'h5A5;
      else rgb_in = 12'h000;
      #1;
      if (pix_tick === 1'b1 && mx() == 6 + PL && my() == 0) begin
        seen = 1;
        checks++;
        if ({r, g, b} !== 12'hF0A) begin
          errors++;
          $display("FAIL pixel_f0a got %h want f0a", {r, g, b});
        end
      end
      step();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL pixel_timeout got none want f0a");
    end
  endtask

  task automatic test_ena_freeze();
    bit hit;
    bit seen;
    hit = 0;
    seen = 0;
    ena = 1'b1;
    for (int i = 0; i < 2 * HT * CD && !hit; i++) begin
      #1;
      if (mx() == 10) hit = 1;
      else step();
    end
    ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rgb_in = 12'($urandom);
      #1;
      checks++;
      if (x !== 10'd10 || {pix_tick, line_start, frame_start} !== 3'b000) begin
        errors++;
        if (errors < 20) $display("FAIL freeze got x=%0d s=%b want x=10 s=000",
                                  x, {pix_tick, line_start, frame_start});
      end
      step();
    end
    ena = 1'b1;
    for (int i = 0; i < CD + 1 && !seen; i++) begin
      #1;
      if (pix_tick === 1'b1) seen = 1;
      step();
    end
    #1;
    checks++;
    if (!seen || x !== 10'd11) begin
      errors++;
      $display("FAIL resume got x=%0d tick=%b want x=11 tick=1", x, seen);
    end
    for (int i = 0; i < 600; i++) begin
      ena = 1'($urandom_range(0, 3) != 0);
      rgb_in = 12'($urandom);
      #1;
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        if (errors < 20) $display("FAIL ena_rand got %h want %h", dut_vec, m_vec());
      end
      step();
    end
  endtask

  task automatic test_midreset();
    bit seen;
    seen = 0;
    ena = 1'b1;
    for (int i = 0; i < int'($urandom_range(100, 700)); i++) begin
      rgb_in = 12'($urandom);
      step();
    end
    rst_n = 1'b0;
    step();
    #1;
    checks++;
    if (x !== 10'd0 || y !== 10'd0 || pix_tick !== 1'b0) begin
      errors++;
      $display("FAIL midrst_xy got %0d,%0d,%b want 0,0,0", x, y, pix_tick);
    end
    checks++;
    if (hs !== !HP || vs !== !VP) begin
      errors++;
      $display("FAIL midrst_sync got %b%b want %b%b", hs, vs, !HP, !VP);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < CD + 2 && !seen; i++) begin
      #1;
      if (pix_tick === 1'b1) begin
        seen = 1;
        checks++;
        if (frame_start !== 1'b1) begin
          errors++;
          $display("FAIL first_frame got %b want 1", frame_start);
        end
      end
      step();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL first_tick_timeout got none want tick");
    end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    test_raster(HT * CD * 4);
  endtask

  initial begin
    test_reset();
    test_raster(1700);
    test_blanking();
    test_pixel();
    test_ena_freeze();
    test_midreset();
    test_raster(400);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
